// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rv32imc_types -- shared types for the unified-memory arbiter.
//
// Purpose:
//   Holds the arbiter state encoding, the pending-request record kept for
//   each CPU port, and a small helper that word-aligns a byte address.
//
// Contents:
//   arb_state_t  IDLE / IBUSY / DBUSY arbiter states
//   arb_req_t    one buffered request: addr, rmask, wmask, wdata, valid
//   word_align() clears the two byte-offset bits of an address
// ---------------------------------------------------------------------------
package rv32imc_types;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        logic        valid;
    } arb_req_t;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    // Memory is word-addressed; byte lanes are selected by the masks instead.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/mem_arb_req_buf.sv
// ---------------------------------------------------------------------------
// mem_arb_req_buf -- single-entry pending buffer for one CPU memory port.
//
// Purpose:
//   Captures a request at the end of the cycle it is presented, holds it
//   while it waits for and receives service, and releases it when the
//   arbiter reports completion. A request arriving while the entry is
//   occupied is rejected and flagged so the arbiter can raise its error.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset, empties the entry
//   req         incoming request (valid = a nonzero mask this cycle)
//   clear       the held entry completes this cycle
//   entry_next  value the entry will hold after this clock edge
//   drop        incoming request rejected because the entry is occupied
// ---------------------------------------------------------------------------
module mem_arb_req_buf
    import rv32imc_types::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  arb_req_t req,
    input  logic     clear,
    output arb_req_t entry_next,
    output logic     drop
);

    arb_req_t entry;

    // The entry stays occupied while in service, so a request on the same
    // cycle as its own completion is still treated as a collision.
    assign drop = req.valid && entry.valid;

    // Next-entry value is exported so the arbiter can grant a request in
    // the very cycle it is being captured.
    always_comb begin
        entry_next = entry;
        if (clear) begin
            entry_next.valid = 1'b0;
        end
        if (req.valid && !entry.valid) begin
            entry_next = req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry <= '0;
        end else begin
            entry <= entry_next;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter -- arbitrates instruction-fetch and data ports onto a single
// unified memory interface.
//
// Purpose:
//   Each port's request is captured into its own pending buffer. An FSM
//   grants one buffered request at a time, drives a registered memory
//   command that stays stable until mem_resp, then passes the returned data
//   straight through to the granted port alongside a one-cycle resp pulse.
//   Collisions, conflicting dmem masks and a busy timeout set a sticky err.
//
// Configuration:
//   MEM_ARBITER_RR_EN  when defined, a last-grant flag makes simultaneous
//                      requests alternate between ports; otherwise dmem
//                      always wins over imem.
//
// Parameters:
//   TIMEOUT_CYCLES  busy cycles without mem_resp before err is raised
//
// Ports:
//   clk, rst_n                            clock, async active-low reset
//   imem_addr, imem_rmask                 fetch request
//   imem_rdata, imem_resp                 fetch data and completion pulse
//   dmem_addr, dmem_rmask, dmem_wmask,
//   dmem_wdata                            load/store request
//   dmem_rdata, dmem_resp                 load data and completion pulse
//   mem_addr, mem_read, mem_write,
//   mem_wmask, mem_wdata                  unified memory command
//   mem_rdata, mem_resp                   unified memory return
//   err                                   sticky protocol/timeout error
// ---------------------------------------------------------------------------
module mem_arbiter
    import rv32imc_types::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,

    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,

    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,

    output logic        err
);

    localparam int            CW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

    arb_state_t    state;
    logic [CW-1:0] busy_cnt;

    arb_req_t i_req;
    arb_req_t d_req;
    arb_req_t i_next;
    arb_req_t d_next;
    arb_req_t grant;

    logic i_clear;
    logic d_clear;
    logic i_drop;
    logic d_drop;
    logic busy;
    logic can_arb;
    logic pick_d;
    logic mask_conflict;
    logic timeout_hit;

`ifdef MEM_ARBITER_RR_EN
    logic last_dmem;
`endif

    // Fetches never write, so their write fields are carried as zero.
    assign i_req = '{addr: imem_addr, rmask: imem_rmask, wmask: 4'h0,
                     wdata: 32'h0, valid: |imem_rmask};
    assign d_req = '{addr: dmem_addr, rmask: dmem_rmask, wmask: dmem_wmask,
                     wdata: dmem_wdata, valid: (|dmem_rmask) || (|dmem_wmask)};

    assign busy    = (state != IDLE);
    assign i_clear = (state == IBUSY) && mem_resp;
    assign d_clear = (state == DBUSY) && mem_resp;

    // A new grant is possible from IDLE, or in the completing cycle of a
    // transaction so the next one starts with no idle gap.
    assign can_arb = !busy || mem_resp;

    mem_arb_req_buf u_ibuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (i_req),
        .clear      (i_clear),
        .entry_next (i_next),
        .drop       (i_drop)
    );

    mem_arb_req_buf u_dbuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (d_req),
        .clear      (d_clear),
        .entry_next (d_next),
        .drop       (d_drop)
    );

    // Arbitration looks at next-cycle pending state so a request presented
    // in cycle N can already be the command in cycle N+1.
`ifdef MEM_ARBITER_RR_EN
    assign pick_d = d_next.valid && (!i_next.valid || !last_dmem);
`else
    assign pick_d = d_next.valid;
`endif

    assign grant = pick_d ? d_next : i_next;

    assign mask_conflict = (|dmem_rmask) && (|dmem_wmask);

    // The counter saturates at CNT_MAX; err fires on the step that reaches it.
    assign timeout_hit = busy && !mem_resp && ((busy_cnt + CW'(1)) == CNT_MAX);

    // Completion is combinational from mem_resp so the port sees it in the
    // same cycle as the memory.
    assign imem_resp  = (state == IBUSY) && mem_resp;
    assign dmem_resp  = (state == DBUSY) && mem_resp;
    assign imem_rdata = imem_resp ? mem_rdata : 32'h0;
    assign dmem_rdata = dmem_resp ? mem_rdata : 32'h0;

    // Arbiter FSM. The memory command is loaded only at grant time and is
    // otherwise left untouched, which keeps it stable until mem_resp. A
    // request with any write lane is a write even if rmask is also set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy_cnt  <= '0;
            err       <= 1'b0;
            mem_addr  <= 32'h0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_wmask <= 4'h0;
            mem_wdata <= 32'h0;
`ifdef MEM_ARBITER_RR_EN
            last_dmem <= 1'b0;
`endif
        end else begin
            err <= err | i_drop | d_drop | mask_conflict | timeout_hit;

            if (can_arb) begin
                busy_cnt <= '0;
                if (grant.valid) begin
                    state     <= pick_d ? DBUSY : IBUSY;
                    mem_addr  <= word_align(grant.addr);
                    mem_write <= |grant.wmask;
                    mem_read  <= (|grant.rmask) && !(|grant.wmask);
                    mem_wmask <= grant.wmask;
                    mem_wdata <= grant.wdata;
`ifdef MEM_ARBITER_RR_EN
                    last_dmem <= pick_d;
`endif
                end else begin
                    state     <= IDLE;
                    mem_addr  <= 32'h0;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    mem_wmask <= 4'h0;
                    mem_wdata <= 32'h0;
                end
            end else if (busy_cnt != CNT_MAX) begin
                busy_cnt <= busy_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter -- self-checking bench for mem_arbiter.
//
// Drives a table of hand-derived cycle vectors, several hand-written
// multi-cycle sequences (store hold, collision, mask conflict, timeout,
// reset mid-transaction) and a randomized run checked against a
// transaction-level reference model. Built with TIMEOUT_CYCLES = 8.
// Honours MEM_ARBITER_RR_EN for the arbitration expectations.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr = '0;
    logic [3:0]  imem_rmask = '0;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] dmem_addr = '0;
    logic [3:0]  dmem_rmask = '0;
    logic [3:0]  dmem_wmask = '0;
    logic [31:0] dmem_wdata = '0;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_resp = 1'b0;
    logic        err;

    mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_addr  (imem_addr),
        .imem_rmask (imem_rmask),
        .imem_rdata (imem_rdata),
        .imem_resp  (imem_resp),
        .dmem_addr  (dmem_addr),
        .dmem_rmask (dmem_rmask),
        .dmem_wmask (dmem_wmask),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp),
        .mem_addr   (mem_addr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_wmask  (mem_wmask),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_resp   (mem_resp),
        .err        (err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [3:0]  irm;
        logic [31:0] iaddr;
        logic [3:0]  drm;
        logic [3:0]  dwm;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        resp;
        logic [31:0] rdata;
        logic        e_read;
        logic        e_write;
        logic [31:0] e_addr;
        logic [3:0]  e_wmask;
        logic        e_iresp;
        logic        e_dresp;
        logic [31:0] e_irdata;
        logic [31:0] e_drdata;
        logic        e_err;
    } vec_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        logic        valid;
    } ent_t;

    // Reference model: one slot per port (0 = imem, 1 = dmem), index of the
    // port in service (-1 when idle), busy cycles of the current service.
    ent_t m_pend [2];
    int   m_serv;
    int   m_busy;
    logic m_err;
    int   m_last;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic compare_all(input string tag, input logic e_read, input logic e_write,
                               input logic [31:0] e_addr, input logic [3:0] e_wmask,
                               input logic [31:0] e_wdata, input logic e_iresp,
                               input logic e_dresp, input logic [31:0] e_irdata,
                               input logic [31:0] e_drdata, input logic e_err);
        check_output({tag, ".mem_read"},  32'(mem_read),  32'(e_read));
        check_output({tag, ".mem_write"}, 32'(mem_write), 32'(e_write));
        check_output({tag, ".mem_wmask"}, 32'(mem_wmask), 32'(e_wmask));
        if (e_read || e_write) check_output({tag, ".mem_addr"}, mem_addr, e_addr);
        if (e_write) check_output({tag, ".mem_wdata"}, mem_wdata, e_wdata);
        check_output({tag, ".imem_resp"},  32'(imem_resp), 32'(e_iresp));
        check_output({tag, ".dmem_resp"},  32'(dmem_resp), 32'(e_dresp));
        check_output({tag, ".imem_rdata"}, imem_rdata, e_irdata);
        check_output({tag, ".dmem_rdata"}, dmem_rdata, e_drdata);
        check_output({tag, ".err"}, 32'(err), 32'(e_err));
    endtask

    task automatic apply_stimulus(input logic [3:0] irm, input logic [31:0] iaddr,
                                  input logic [3:0] drm, input logic [3:0] dwm,
                                  input logic [31:0] daddr, input logic [31:0] dwdata,
                                  input logic resp, input logic [31:0] rdata);
        @(negedge clk);
        imem_rmask = irm;
        imem_addr  = iaddr;
        dmem_rmask = drm;
        dmem_wmask = dwm;
        dmem_addr  = daddr;
        dmem_wdata = dwdata;
        mem_resp   = resp;
        mem_rdata  = rdata;
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        compare_all(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output({tag, ".mem_addr"},  mem_addr,  32'h0);
        check_output({tag, ".mem_wdata"}, mem_wdata, 32'h0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        imem_rmask = '0; imem_addr = '0;
        dmem_rmask = '0; dmem_wmask = '0; dmem_addr = '0; dmem_wdata = '0;
        mem_resp = 1'b0; mem_rdata = '0;
        #1;
        check_all_zero(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic model_reset();
        m_pend[0] = '0;
        m_pend[1] = '0;
        m_serv = -1;
        m_busy = 0;
        m_err  = 1'b0;
        m_last = 0;
    endtask

    task automatic model_step(input ent_t ir, input ent_t dr, input logic resp);
        ent_t req [2];
        int   pick;
        req[0] = ir;
        req[1] = dr;
        if (dr.valid && (|dr.rmask) && (|dr.wmask)) m_err = 1'b1;
        for (int p = 0; p < 2; p++) begin
            if (req[p].valid) begin
                if (m_pend[p].valid) m_err = 1'b1;
                else m_pend[p] = req[p];
            end
        end
        if (m_serv >= 0 && !resp) begin
            if (m_busy < TMO) begin
                m_busy++;
                if (m_busy == TMO) m_err = 1'b1;
            end
        end else begin
            if (m_serv >= 0) m_pend[m_serv].valid = 1'b0;
            if (m_pend[0].valid && m_pend[1].valid) begin
`ifdef MEM_ARBITER_RR_EN
                pick = 1 - m_last;
`else
                pick = 1;
`endif
            end else if (m_pend[1].valid) pick = 1;
            else if (m_pend[0].valid) pick = 0;
            else pick = -1;
            m_serv = pick;
            if (pick >= 0) m_last = pick;
            m_busy = 0;
        end
    endtask

    function automatic vec_t v(logic [3:0] irm, logic [31:0] iaddr, logic [3:0] drm,
                               logic [3:0] dwm, logic [31:0] daddr, logic [31:0] dwdata,
                               logic resp, logic [31:0] rdata, logic e_read, logic e_write,
                               logic [31:0] e_addr, logic [3:0] e_wmask, logic e_iresp,
                               logic e_dresp, logic [31:0] e_irdata, logic [31:0] e_drdata,
                               logic e_err);
        vec_t r;
        r.irm = irm; r.iaddr = iaddr; r.drm = drm; r.dwm = dwm; r.daddr = daddr;
        r.dwdata = dwdata; r.resp = resp; r.rdata = rdata; r.e_read = e_read;
        r.e_write = e_write; r.e_addr = e_addr; r.e_wmask = e_wmask; r.e_iresp = e_iresp;
        r.e_dresp = e_dresp; r.e_irdata = e_irdata; r.e_drdata = e_drdata; r.e_err = e_err;
        return r;
    endfunction

    initial begin
        vec_t tbl[$];
        ent_t ir;
        ent_t dr;
        ent_t cur;
        logic e_w;

        // Single fetch with mem_resp tied high (ignored while idle).
        tbl.push_back(v(4'hF, 32'h1000_0006, 0, 0, 0, 0, 1, 32'hAAAA_5555, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h1234_5678, 1, 0, 32'h1000_0004, 0, 1, 0, 32'h1234_5678, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Simultaneous fetch and load, latency 3; last grant was imem so dmem wins.
        tbl.push_back(v(4'hF, 32'h2000, 4'hF, 0, 32'h3008, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h3008, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h3008, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'hCAFE_F00D, 1, 0, 32'h3008, 0, 0, 1, 0, 32'hCAFE_F00D, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h2000, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h2000, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h0BAD_C0DE, 1, 0, 32'h2000, 0, 1, 0, 32'h0BAD_C0DE, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // A lone dmem load makes dmem the last grant.
        tbl.push_back(v(0, 0, 4'h1, 0, 32'h43, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h11, 1, 0, 32'h40, 0, 0, 1, 0, 32'h11, 0));
        // Both pending again, back-to-back single-cycle responses.
        tbl.push_back(v(4'hF, 32'h50, 4'hF, 0, 32'h60, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef MEM_ARBITER_RR_EN
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h22, 1, 0, 32'h50, 0, 1, 0, 32'h22, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h33, 1, 0, 32'h60, 0, 0, 1, 0, 32'h33, 0));
`else
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h22, 1, 0, 32'h60, 0, 0, 1, 0, 32'h22, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h33, 1, 0, 32'h50, 0, 1, 0, 32'h33, 0, 0));
`endif
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        do_reset("reset0");
        foreach (tbl[i]) begin
            apply_stimulus(tbl[i].irm, tbl[i].iaddr, tbl[i].drm, tbl[i].dwm,
                           tbl[i].daddr, tbl[i].dwdata, tbl[i].resp, tbl[i].rdata);
            compare_all($sformatf("tbl%0d", i), tbl[i].e_read, tbl[i].e_write, tbl[i].e_addr,
                        tbl[i].e_wmask, 32'h0, tbl[i].e_iresp, tbl[i].e_dresp,
                        tbl[i].e_irdata, tbl[i].e_drdata, tbl[i].e_err);
        end

        // Store held for five cycles until mem_resp.
        apply_stimulus(0, 0, 0, 4'h3, 32'h104, 32'hDEAD_BEEF, 0, 0);
        compare_all("st_req", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
            compare_all($sformatf("st_hold%0d", k), 0, 1, 32'h104, 4'h3, 32'hDEAD_BEEF,
                        0, 0, 0, 0, 0);
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 32'h55);
        compare_all("st_resp", 0, 1, 32'h104, 4'h3, 32'hDEAD_BEEF, 0, 1, 0, 32'h55, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        compare_all("st_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Second fetch while the first is pending is dropped.
        apply_stimulus(4'hF, 32'h200, 0, 0, 0, 0, 0, 0);
        compare_all("drop_req1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(4'hF, 32'h300, 0, 0, 0, 0, 0, 0);
        compare_all("drop_req2", 1, 0, 32'h200, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 32'h77);
        compare_all("drop_resp", 1, 0, 32'h200, 0, 0, 1, 0, 32'h77, 0, 1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        compare_all("drop_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Both dmem masks set: issued as a write and flagged.
        do_reset("reset1");
        apply_stimulus(0, 0, 4'hF, 4'hC, 32'h10, 32'h99, 0, 0);
        compare_all("both_req", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 32'h0);
        compare_all("both_resp", 0, 1, 32'h10, 4'hC, 32'h99, 0, 1, 0, 0, 1);

        // Timeout: err appears after eight busy cycles, command stays up.
        do_reset("reset2");
        apply_stimulus(4'hF, 32'h400, 0, 0, 0, 0, 0, 0);
        compare_all("tmo_req", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= TMO; k++) begin
            apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
            compare_all($sformatf("tmo_busy%0d", k), 1, 0, 32'h400, 0, 0, 0, 0, 0, 0, 0);
        end
        for (int k = 0; k < 2; k++) begin
            apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
            compare_all($sformatf("tmo_err%0d", k), 1, 0, 32'h400, 0, 0, 0, 0, 0, 0, 1);
        end

        // Reset mid-DBUSY, then a stale response.
        do_reset("reset3");
        apply_stimulus(0, 0, 4'hF, 0, 32'h500, 0, 0, 0);
        compare_all("rst_req", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        compare_all("rst_busy", 1, 0, 32'h500, 0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_low");
        mem_resp = 1'b1;
        mem_rdata = 32'hEE;
        #1 check_all_zero("rst_low_resp");
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 32'hEE);
        check_all_zero("rst_stale");
        apply_stimulus(0, 0, 4'hF, 0, 32'h600, 0, 0, 0);
        compare_all("rst_new_req", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 32'h66);
        compare_all("rst_new_resp", 1, 0, 32'h600, 0, 0, 0, 1, 0, 32'h66, 0);

        // Randomized traffic against the reference model.
        do_reset("rnd_reset");
        model_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic [3:0]  irm;
            logic [3:0]  drm;
            logic [3:0]  dwm;
            logic [31:0] iaddr;
            logic [31:0] daddr;
            logic [31:0] dwdata;
            logic [31:0] rdata;
            logic        resp;
            int          kind;
            if (cyc % 100 == 99) begin
                do_reset($sformatf("rnd_reset%0d", cyc));
                model_reset();
                continue;
            end
            irm = 0; drm = 0; dwm = 0;
            iaddr = $urandom; daddr = $urandom; dwdata = $urandom; rdata = $urandom;
            resp = ($urandom_range(0, 1) == 1);
            if ((!m_pend[0].valid && $urandom_range(0, 2) == 0) || $urandom_range(0, 39) == 0)
                irm = 4'($urandom_range(1, 15));
            if ((!m_pend[1].valid && $urandom_range(0, 2) == 0) || $urandom_range(0, 39) == 0) begin
                kind = $urandom_range(0, 7);
                if (kind <= 3) drm = 4'($urandom_range(1, 15));
                else if (kind <= 6) dwm = 4'($urandom_range(1, 15));
                else begin
                    drm = 4'($urandom_range(1, 15));
                    dwm = 4'($urandom_range(1, 15));
                end
            end
            apply_stimulus(irm, iaddr, drm, dwm, daddr, dwdata, resp, rdata);

            if (m_serv >= 0) cur = m_pend[m_serv];
            else cur = '0;
            e_w = (m_serv >= 0) && (|cur.wmask);
            compare_all($sformatf("rnd%0d", cyc), (m_serv >= 0) && !e_w, e_w,
                        cur.addr & 32'hFFFF_FFFC, (m_serv >= 0) ? cur.wmask : 4'h0, cur.wdata,
                        (m_serv == 0) && resp, (m_serv == 1) && resp,
                        ((m_serv == 0) && resp) ? rdata : 32'h0,
                        ((m_serv == 1) && resp) ? rdata : 32'h0, m_err);

            ir = '{addr: iaddr, rmask: irm, wmask: 4'h0, wdata: 32'h0, valid: (irm != 0)};
            dr = '{addr: daddr, rmask: drm, wmask: dwm, wdata: dwdata,
                   valid: (drm != 0) || (dwm != 0)};
            model_step(ir, dr, resp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1023, busy cycles without mem_resp before err is raised.
REQ-002 clk  input  1  rising-edge clock; one clock domain.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 imem_addr  input  32  instruction fetch address.
REQ-005 imem_rmask  input  4  fetch read mask; nonzero for one cycle means a fetch request.
REQ-006 imem_rdata  output  32  fetch data; valid when imem_resp is high.
REQ-007 imem_resp  output  1  one-cycle fetch completion pulse.
REQ-008 dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata  input  32/4/4/32  data request; a nonzero mask for one cycle means a request.
REQ-009 dmem_rdata  output  32  load data; valid when dmem_resp is high.
REQ-010 dmem_resp  output  1  one-cycle load/store completion pulse.
REQ-011 mem_addr, mem_read, mem_write, mem_wmask, mem_wdata  output  32/1/1/4/32  unified memory command.
REQ-012 mem_rdata, mem_resp  input  32/1  unified memory return data and completion.
REQ-013 err  output  1  sticky protocol/timeout error.

Function
REQ-014 A request present in cycle N shall be captured into that port's pending buffer (addr, masks, wdata) at the end of cycle N.
REQ-015 States: IDLE, IBUSY, DBUSY; IDLE shall grant DBUSY if dmem is pending, else IBUSY if imem is pending, else stay in IDLE.
REQ-016 Minimum latency: request in cycle N -> command in N+1 -> if mem_resp is high in N+1, the port resp shall also be high in N+1.
REQ-017 In BUSY states, the command (mem_read or mem_write, mem_addr, mem_wmask, mem_wdata) shall be held stable until mem_resp is sampled high.
REQ-018 mem_addr shall be {addr[31:2],2'b00}.
REQ-019 dmem with nonzero wmask shall issue mem_write; otherwise mem_read; imem shall always issue mem_read.
REQ-020 On mem_resp: pulse the granted port's resp for one cycle, pass mem_rdata through combinationally to that port's rdata, and clear its pending entry.
REQ-021 On mem_resp, the next state shall be chosen by REQ-015 arbitration over the remaining pending entries, with zero idle cycles between transactions.
REQ-022 mem_resp while in IDLE shall be ignored.
REQ-023 A new request on a port whose entry is pending or in service shall be dropped and shall set err.
REQ-024 dmem_rmask and dmem_wmask both nonzero shall be treated as a write and shall set err.
REQ-025 A busy-cycle counter shall clear on each grant, saturate at TIMEOUT_CYCLES, and set err on reaching it; the transaction shall not be aborted.
REQ-026 When not driven by a response, rdata outputs shall be 0; mem_read, mem_write and mem_wmask shall be 0 in IDLE.

Reset
REQ-027 While rst_n is low, all outputs shall be 0, state shall be IDLE, and pending entries, counter and err shall be cleared.
REQ-028 Reset mid-transaction shall abandon the outstanding memory command; a stale mem_resp after reset shall be ignored (REQ-022).

Configuration
REQ-029 With MEM_ARBITER_RR_EN defined, a last-grant flag shall be kept, and when both ports are pending the port not last granted shall win.
REQ-030 Without MEM_ARBITER_RR_EN, dmem shall have fixed priority over imem.

Structure
REQ-031 arb_state_t (IDLE/IBUSY/DBUSY) and the arb_req_t struct (addr, rmask, wmask, wdata, valid) shall be added to package rv32imc_types.
REQ-032 Each port's pending buffer shall be one sub-module, mem_arb_req_buf, instantiated twice.

Verification
REQ-033 Single fetch: imem_rmask=4'hF, addr=0x1000_0006 in cycle 0, with mem_resp tied high -> mem_read and mem_addr=0x1000_0004 in cycle 1, imem_resp in cycle 1 with data passed through.
REQ-034 Simultaneous imem and dmem load in the same cycle, memory latency 3 -> dmem served first, then imem back-to-back with no IDLE cycle; with RR_EN and a prior dmem grant, imem is served first.
REQ-035 Store: dmem_wmask=4'h3, wdata=0xDEAD_BEEF -> mem_write=1, mem_wmask=4'h3, command held 5 cycles until mem_resp, then one dmem_resp pulse.
REQ-036 Second imem request while a fetch is pending -> request dropped, err=1, first fetch completes normally.
REQ-037 TIMEOUT_CYCLES=8 with mem_resp never asserted -> err rises after 8 busy cycles and mem_read stays high.
REQ-038 rst_n pulsed low mid-DBUSY, then a stray mem_resp -> all outputs 0, no dmem_resp pulse, state IDLE.
